// File: rtl/cordic_phase_feeder_pkg.sv
// Shared constants and FSM encoding for the CORDIC phase feeder and its angle fold.
package cordic_phase_feeder_pkg;

    localparam int ITERATIONS_DEF = 16;
    localparam int XY_BITS_DEF    = 16;
    localparam int THETA_BITS_DEF = 16;
    localparam int XY_W           = XY_BITS_DEF + 1;
    localparam int THETA_W        = THETA_BITS_DEF + 1;
    localparam int PHASE_W        = 16;
    localparam int FRAC_W         = 14;
    localparam int PROD_W         = 30;
    localparam int CORDIC_1_DEF   = 19898;
    localparam int HALF_PI_Q15    = 51472;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_ITER,
        ST_OUT
    } state_t;

endpackage

// File: rtl/cordic_quadrant_fold.sv
// Folds a 16-bit turn-fraction phase into a quadrant and a first-quadrant angle in radians.
module cordic_quadrant_fold
    import cordic_phase_feeder_pkg::*;
#(
    parameter int THETA_BITS = THETA_BITS_DEF
) (
    input  logic [PHASE_W-1:0]  phase,
    output logic [1:0]          quad,
    output logic [THETA_BITS:0] theta
);

    logic [PROD_W-1:0] prod;

    assign quad  = phase[PHASE_W-1 -: 2];
    // Quarter-turn fraction scaled to radians: frac * (pi/2 in Q15) / 2^14, truncated.
    assign prod  = PROD_W'(phase[FRAC_W-1:0]) * PROD_W'(HALF_PI_Q15);
    assign theta = (THETA_BITS + 1)'(prod >> FRAC_W);

endmodule

// File: rtl/cordic_phase_feeder.sv
// Phase accumulator and sequencer driving an external iterative CORDIC; unfolds its result to sin/cos.
module cordic_phase_feeder
    import cordic_phase_feeder_pkg::*;
#(
    parameter int ITERATIONS = ITERATIONS_DEF,
    parameter int XY_BITS    = XY_BITS_DEF,
    parameter int THETA_BITS = THETA_BITS_DEF,
    parameter int CORDIC_1   = CORDIC_1_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic [PHASE_W-1:0]        phase_inc,
    input  logic                      phase_clr,
    output logic                      cordic_init,
    output logic signed [XY_BITS:0]   cordic_x_i,
    output logic signed [XY_BITS:0]   cordic_y_i,
    output logic [THETA_BITS:0]       cordic_theta_i,
    input  logic signed [XY_BITS:0]   cordic_x_o,
    input  logic signed [XY_BITS:0]   cordic_y_o,
    output logic signed [XY_BITS:0]   sin_o,
    output logic signed [XY_BITS:0]   cos_o,
    output logic                      out_valid,
    output logic                      busy,
    output logic [PHASE_W-1:0]        phase_o
);

    localparam int CNT_W = $clog2(ITERATIONS) + 1;

    state_t                   state, state_nxt;
    logic [CNT_W-1:0]         cnt;
    logic [PHASE_W-1:0]       phase_q;
    logic [PHASE_W-1:0]       sample_phase;
    logic [1:0]               quad_q;
    logic [1:0]               fold_quad;
    logic [THETA_BITS:0]      fold_theta;
    logic signed [XY_BITS:0]  sin_nxt, cos_nxt;

    // Theta follows the phase register, which only moves at OUT, so it is steady LOAD..OUT.
    cordic_quadrant_fold #(.THETA_BITS(THETA_BITS)) u_fold (
        .phase (phase_q),
        .quad  (fold_quad),
        .theta (fold_theta)
    );

    assign cordic_init    = (state == ST_LOAD);
    assign cordic_x_i     = (XY_BITS + 1)'(CORDIC_1);
    assign cordic_y_i     = '0;
    assign cordic_theta_i = fold_theta;
    assign busy           = (state != ST_IDLE);
    assign phase_o        = sample_phase;

    always_comb begin
        // NOTE: defaults first so every path assigns every output and no latch is inferred.
        state_nxt = state;
        case (state)
            ST_IDLE: if (en) state_nxt = ST_LOAD;
            ST_LOAD: state_nxt = ST_ITER;
            ST_ITER: if (cnt == '0) state_nxt = ST_OUT;
            ST_OUT:  state_nxt = en ? ST_LOAD : ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
        if (phase_clr) state_nxt = ST_IDLE;
    end

    always_comb begin
        sin_nxt = cordic_y_o;
        cos_nxt = cordic_x_o;
        case (quad_q)
            2'd0: begin sin_nxt =  cordic_y_o; cos_nxt =  cordic_x_o; end
            2'd1: begin sin_nxt =  cordic_x_o; cos_nxt = -cordic_y_o; end
            2'd2: begin sin_nxt = -cordic_y_o; cos_nxt = -cordic_x_o; end
            2'd3: begin sin_nxt = -cordic_x_o; cos_nxt =  cordic_y_o; end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            phase_q      <= '0;
            sample_phase <= '0;
            quad_q       <= '0;
            sin_o        <= '0;
            cos_o        <= '0;
            out_valid    <= 1'b0;
        end else begin
            state     <= state_nxt;
            out_valid <= 1'b0;
            if (phase_clr) begin
                cnt          <= '0;
                phase_q      <= '0;
                sample_phase <= '0;
            end else begin
                case (state)
                    ST_LOAD: begin
                        cnt          <= CNT_W'(ITERATIONS - 1);
                        quad_q       <= fold_quad;
                        sample_phase <= phase_q;
                    end
                    ST_ITER: if (cnt != '0) cnt <= cnt - CNT_W'(1);
                    ST_OUT: begin
                        sin_o     <= sin_nxt;
                        cos_o     <= cos_nxt;
                        out_valid <= 1'b1;
                        phase_q   <= phase_q + phase_inc;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_cordic_phase_feeder.sv
// Scoreboard bench for cordic_phase_feeder with a behavioural iterative CORDIC wired externally.
module tb_cordic_phase_feeder;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               en = 1'b0;
    logic [15:0]        phase_inc = '0;
    logic               phase_clr = 1'b0;
    logic               cordic_init;
    logic signed [16:0] cordic_x_i, cordic_y_i, cordic_x_o, cordic_y_o;
    logic [16:0]        cordic_theta_i;
    logic signed [16:0] sin_o, cos_o;
    logic               out_valid, busy;
    logic [15:0]        phase_o;

    cordic_phase_feeder dut (
        .clk            (clk),
        .rst            (rst),
        .en             (en),
        .phase_inc      (phase_inc),
        .phase_clr      (phase_clr),
        .cordic_init    (cordic_init),
        .cordic_x_i     (cordic_x_i),
        .cordic_y_i     (cordic_y_i),
        .cordic_theta_i (cordic_theta_i),
        .cordic_x_o     (cordic_x_o),
        .cordic_y_o     (cordic_y_o),
        .sin_o          (sin_o),
        .cos_o          (cos_o),
        .out_valid      (out_valid),
        .busy           (busy),
        .phase_o        (phase_o)
    );

    always #5 clk = ~clk;

    // Iterative rotator: loads on cordic_init, then one micro-rotation per clock for 16 clocks.
    int atan_tab [16] = '{25736, 15193, 8027, 4075, 2045, 1024, 512, 256,
                          128, 64, 32, 16, 8, 4, 2, 1};
    logic signed [19:0] mx = '0, my = '0, mz = '0;
    int mi = 16;

    always @(posedge clk) begin
        if (cordic_init) begin
            mx <= {{3{cordic_x_i[16]}}, cordic_x_i};
            my <= {{3{cordic_y_i[16]}}, cordic_y_i};
            mz <= {3'b000, cordic_theta_i};
            mi <= 0;
        end else if (mi < 16) begin
            if (!mz[19]) begin
                mx <= mx - (my >>> mi);
                my <= my + (mx >>> mi);
                mz <= mz - 20'(atan_tab[mi]);
            end else begin
                mx <= mx + (my >>> mi);
                my <= my - (mx >>> mi);
                mz <= mz + 20'(atan_tab[mi]);
            end
            mi <= mi + 1;
        end
    end

    assign cordic_x_o = mx[16:0];
    assign cordic_y_o = my[16:0];

    typedef struct {
        int sin_v;
        int cos_v;
        int phase;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;
    int   last_ov = -1;
    bit   period_chk = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp_v);
        vectors++;
        if (act != exp_v) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
        end
    endtask

    task automatic check_near(input string name, input int act, input int exp_v, input int tol);
        int d;
        d = act - exp_v;
        if (d < 0) d = -d;
        vectors++;
        if (d > tol) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (+/-%0d)", name, act, exp_v, tol);
        end
    endtask

    task automatic push(input int s, input int c, input int p);
        exp_t e;
        e.sin_v = s;
        e.cos_v = c;
        e.phase = p;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every out_valid pops one expected sample.
    always @(negedge clk) begin
        if (out_valid) begin
            if (sb.size() == 0) begin
                check("unexpected_out_valid", sb.size(), 1);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check_near("sin_o", int'(sin_o), e.sin_v, 10);
                check_near("cos_o", int'(cos_o), e.cos_v, 10);
                check("phase_o", int'(phase_o), e.phase);
            end
            if (period_chk && last_ov >= 0) check("out_valid_period", cyc - last_ov, 18);
            last_ov = cyc;
        end
    end

    // Run n samples with en high, drop en in the last ITER, then confirm the FSM goes quiet.
    task automatic run_samples(input int n, input int exp_theta);
        int got;
        int extra;
        got = 0;
        en  = 1'b1;
        for (int c = 0; c < n * 20 + 40 && got < n; c++) begin
            tick();
            if (cordic_init) begin
                got++;
                if (exp_theta >= 0) check("theta_load", int'(cordic_theta_i), exp_theta);
            end
        end
        check("init_count", got, n);
        repeat (3) tick();
        en = 1'b0;
        if (exp_theta >= 0) begin
            repeat (14) tick();
            check("theta_out", int'(cordic_theta_i), exp_theta);
        end
        for (int c = 0; c < 40 && busy; c++) tick();
        check("busy_after_run", int'(busy), 0);
        extra = 0;
        repeat (25) begin
            tick();
            if (cordic_init) extra++;
        end
        check("no_extra_init", extra, 0);
        check("scoreboard_drained", sb.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int got;
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        check("rst_busy", int'(busy), 0);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_phase_o", int'(phase_o), 0);
        check("rst_cordic_init", int'(cordic_init), 0);
        check("rst_theta", int'(cordic_theta_i), 0);
        check("rst_sin", int'(sin_o), 0);
        check("rst_cos", int'(cos_o), 0);
        check("cordic_x_i", int'(cordic_x_i), 19898);

        // Quarter-turn steps from 0, with pulse spacing checked.
        phase_inc  = 16'h4000;
        period_chk = 1'b1;
        last_ov    = -1;
        push(0, 32768, 16'h0000);
        push(32768, 0, 16'h4000);
        push(0, -32768, 16'h8000);
        push(-32768, 0, 16'hC000);
        run_samples(4, -1);
        period_chk = 1'b0;

        // Move to phase 0x2000 and hold there.
        phase_inc = 16'h2000;
        push(0, 32768, 16'h0000);
        run_samples(1, 0);
        phase_inc = 16'h0000;
        push(23170, 23170, 16'h2000);
        push(23170, 23170, 16'h2000);
        run_samples(2, 25736);

        // Second quadrant at 0x6000.
        phase_inc = 16'h4000;
        push(23170, 23170, 16'h2000);
        run_samples(1, 25736);
        phase_inc = 16'h0000;
        push(23170, -23170, 16'h6000);
        run_samples(1, 25736);

        // Clear in ITER cycle 5 aborts the sample.
        en  = 1'b1;
        got = 0;
        for (int c = 0; c < 40 && got == 0; c++) begin
            tick();
            if (cordic_init) got = 1;
        end
        check("clr_init_seen", got, 1);
        repeat (5) tick();
        phase_clr = 1'b1;
        en        = 1'b0;
        tick();
        phase_clr = 1'b0;
        check("clr_phase_o", int'(phase_o), 0);
        check("clr_busy", int'(busy), 0);
        repeat (20) tick();
        push(0, 32768, 16'h0000);
        run_samples(1, 0);

        // Three-quarter-turn steps wrap backwards through the quadrants.
        phase_inc = 16'hC000;
        push(0, 32768, 16'h0000);
        push(-32768, 0, 16'hC000);
        push(0, -32768, 16'h8000);
        push(32768, 0, 16'h4000);
        push(0, 32768, 16'h0000);
        run_samples(5, -1);

        // en and phase_clr together in IDLE: clear wins, LOAD follows.
        phase_inc = 16'h0000;
        en        = 1'b1;
        phase_clr = 1'b1;
        tick();
        phase_clr = 1'b0;
        check("en_clr_idle_busy", int'(busy), 0);
        tick();
        check("en_clr_then_load", int'(cordic_init), 1);
        check("en_clr_theta", int'(cordic_theta_i), 0);
        push(0, 32768, 16'h0000);
        repeat (3) tick();
        en = 1'b0;
        for (int c = 0; c < 40 && busy; c++) tick();
        check("en_clr_idle_after", int'(busy), 0);
        repeat (5) tick();
        check("en_clr_drained", sb.size(), 0);

        // Reset during OUT discards the sample.
        phase_inc = 16'h1234;
        en  = 1'b1;
        got = 0;
        for (int c = 0; c < 40 && got == 0; c++) begin
            tick();
            if (cordic_init) got = 1;
        end
        check("rst_out_init_seen", got, 1);
        repeat (17) tick();
        check("rst_out_busy_before", int'(busy), 1);
        rst = 1'b1;
        en  = 1'b0;
        tick();
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_busy", int'(busy), 0);
        check("rst_out_sin", int'(sin_o), 0);
        check("rst_out_cos", int'(cos_o), 0);
        check("rst_out_phase_o", int'(phase_o), 0);
        check("rst_out_init", int'(cordic_init), 0);
        check("rst_out_theta", int'(cordic_theta_i), 0);
        rst = 1'b0;
        repeat (25) tick();
        check("final_drained", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/cordic_phase_feeder.md
CORDIC_PHASE_FEEDER -- requirements
Module: cordic_phase_feeder

Interface
REQ-001 Parameter ITERATIONS, default 16: number of CORDIC rotation cycles per sample.
REQ-002 Parameter XY_BITS, default 16: MSB index of the signed x/y data words (data width 17).
REQ-003 Parameter THETA_BITS, default 16: MSB index of the angle word (angle width 17, radians, U(1,15)).
REQ-004 Parameter CORDIC_1, default 19898: gain-compensated unit vector, 32768/1.64676.
REQ-005 clk  in  1  the single clock; all logic is rising-edge.
REQ-006 rst  in  1  reset, synchronous and active-high.
REQ-007 en  in  1  sample generation enable.
REQ-008 phase_inc  in  16  unsigned phase step per sample; 65536 = one full turn.
REQ-009 phase_clr  in  1  synchronous clear of the accumulator and abort of the current sample.
REQ-010 cordic_init  out  1  one-cycle load strobe to the iterative CORDIC.
REQ-011 cordic_x_i / cordic_y_i  out  17 each  start vector: CORDIC_1 and 0.
REQ-012 cordic_theta_i  out  17  first-quadrant angle in radians, U(1,15).
REQ-013 cordic_x_o / cordic_y_o  in  17 each  signed rotator results (cos, sin of the folded angle).
REQ-014 sin_o / cos_o  out  17 each  signed unfolded results, Q1.15.
REQ-015 out_valid  out  1  one-cycle strobe; sin_o and cos_o are valid while it is high.
REQ-016 busy  out  1  high in every state except IDLE.
REQ-017 phase_o  out  16  phase of the sample in flight, or of the last sample produced.

Function
REQ-018 FSM states: IDLE, LOAD, ITER, OUT.
REQ-019 IDLE->LOAD when en=1. Otherwise the FSM stays in IDLE.
REQ-020 LOAD lasts one cycle. cordic_init=1, and cordic_theta_i is computed from the phase register. LOAD->ITER.
REQ-021 ITER lasts exactly ITERATIONS cycles, timed by a down-counter loaded in LOAD. ITER->OUT when the counter reaches 0.
REQ-022 OUT lasts one cycle and captures the unfolded result into sin_o and cos_o. out_valid is asserted in the cycle after OUT.
REQ-023 OUT always updates the phase register to phase + phase_inc (mod 2^16), sampling phase_inc in that cycle.
REQ-024 OUT->LOAD if en=1, else OUT->IDLE.
REQ-025 Sample period when en is held high: ITERATIONS+2 cycles (18 at defaults).
REQ-026 en deasserted mid-sample: the current sample completes; the FSM then returns to IDLE.
REQ-027 Angle fold: quadrant q = phase[15:14] and frac = phase[13:0].
REQ-028 theta = (frac * 51472) >> 14, truncated, with a 30-bit unsigned intermediate. 51472 = HALF_PI_Q15.
REQ-029 theta is held stable on cordic_theta_i from LOAD through OUT.
REQ-030 The quadrant is registered in LOAD and used at OUT.
REQ-031 Unfold per quadrant, with negation in two's complement at 17 bits:
- q0: sin=y, cos=x
- q1: sin=x, cos=-y
- q2: sin=-y, cos=-x
- q3: sin=-x, cos=y
REQ-032 phase_clr has priority over all other activity. In any state it sets the phase register to 0, sets the FSM to IDLE and the counter to 0, and suppresses out_valid, including for an OUT in the same cycle.
REQ-033 en and phase_clr asserted together in IDLE: the clear wins; LOAD begins on the next cycle if en is still high.
REQ-034 Phase wrap past 0xFFFF is silent modular wrap.

Reset
REQ-035 rst=1 forces, on the next edge:
- FSM to IDLE; phase register, counter and quadrant register to 0
- cordic_init=0, cordic_theta_i=0, sin_o=0, cos_o=0
- out_valid=0, busy=0, phase_o=0
REQ-036 rst mid-sample discards the sample; no out_valid is produced.
REQ-037 rst overrides phase_clr and en.

Structure
REQ-038 A shared package holds: HALF_PI_Q15=51472, CORDIC_1=19898, the ITERATIONS default, the data and angle widths, and the FSM state enumeration.
REQ-039 The fold (phase to q, theta) is a natural combinational sub-module, cordic_quadrant_fold. Everything else is a single module.
REQ-040 The CORDIC is not instantiated inside this block. The bench connects it externally in ITERATE configuration.

Verification
REQ-041 phase_inc=16384 from 0 with en=1: successive (sin,cos) are (0,32768), (32768,0), (0,-32768), (-32768,0), each within ±10 LSB; out_valid pulses are exactly 18 cycles apart.
REQ-042 Phase 0x2000 held with phase_inc=0: cordic_theta_i=25736 during LOAD through OUT; sin and cos are both 23170 ±10.
REQ-043 phase_inc=0xC000: phase_o sequence is 0, 0xC000, 0x8000, 0x4000, 0 (wrap), with the matching quadrant signs.
REQ-044 phase_clr pulsed in ITER cycle 5: no out_valid for that sample; phase_o=0 and busy=0 next cycle; the next sample is (0,32768).
REQ-045 en dropped during ITER: that sample completes with one out_valid, then busy=0 and no further cordic_init.
REQ-046 rst asserted in OUT: out_valid stays 0 and all outputs read 0 on the next cycle.
